// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined floating-point adder/subtractor.
package fp_pkg;

    // Operand class after subnormal flushing.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Bit positions inside the {invalid, overflow, inexact} flag vector.
    localparam int FLAG_INEXACT  = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INVALID  = 2;
    localparam int NUM_FLAGS     = 3;

    // Widest word the constant helpers can build; callers truncate to their width.
    localparam int MAX_W = 128;

    // Subnormals (zero exponent) are classed as ZERO, which is how they get flushed.
    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic man_zero);
        if (exp_zero)      return ZERO;
        else if (!exp_ones) return NORM;
        else if (man_zero) return INF;
        else               return NAN;
    endfunction

    // Positive infinity: all-ones exponent, zero mantissa.
    function automatic logic [MAX_W-1:0] inf_pos(input int exp_w, input int man_w);
        logic [MAX_W-1:0] ones;
        ones = (MAX_W'(1) << exp_w) - MAX_W'(1);
        return ones << man_w;
    endfunction

    // Canonical NaN: sign set, all-ones exponent, only the mantissa MSB set.
    function automatic logic [MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
        return inf_pos(exp_w, man_w)
             | (MAX_W'(1) << (man_w - 1))
             | (MAX_W'(1) << (man_w + exp_w));
    endfunction

    // Width-independent control carried alongside every stage payload.
    typedef struct packed {
        logic                 bypass;   // result fully decided in S1
        logic                 sign;     // sign of the larger-magnitude operand
        logic                 eff_sub;  // significands are subtracted
        logic [NUM_FLAGS-1:0] flags;    // flags of the bypass result
    } stage_ctl_t;

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        // NOTE: assigning a default before any conditional write keeps this purely combinational (no latch).
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Four-stage IEEE-754-style adder/subtractor with RNE rounding, flush-to-zero
// on input and output, and a single global stall driven by the output handshake.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [NUM_FLAGS-1:0]     out_flags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;          // significand with hidden bit
    localparam int EXT_W  = MAN_W + 4;          // significand + guard/round/sticky
    localparam int SUM_W  = MAN_W + 5;          // plus carry-out
    localparam int LZ_W   = $clog2(EXT_W + 1);
    localparam int MAX_SH = MAN_W + 3;
    localparam int SH_W   = $clog2(MAX_SH + 1);
    localparam int EXPS_W = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

    localparam logic [W-1:0] QNAN    = W'(canon_nan(EXP_W, MAN_W));
    localparam logic [W-1:0] INF_POS = W'(inf_pos(EXP_W, MAN_W));
    localparam logic signed [EXPS_W-1:0] EXP_MAX_S = EXPS_W'((1 << EXP_W) - 1);

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [W-1:0]     byp_result;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig_l;
        logic [SIG_W-1:0] sig_s;
        logic [EXP_W-1:0] diff;
    } s1_t;

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [W-1:0]     byp_result;
        logic [EXP_W-1:0] exp;
        logic [EXT_W-1:0] sig_l;
        logic [EXT_W-1:0] sig_s;
    } s2_t;

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [W-1:0]     byp_result;
        logic [EXP_W-1:0] exp;
        logic [SUM_W-1:0] sum;
        logic [LZ_W-1:0]  lz;
    } s3_t;

    logic advance;
    logic v1_q, v2_q, v3_q;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;

    // Every stage moves together whenever the output slot is free or being drained.
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- S1: unpack, classify, specials, order by magnitude
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    fp_class_e        a_cls, b_cls;
    logic [W-2:0]     a_mag, b_mag;
    logic             a_ge_b;

    assign a_sign = in_a[W-1];
    assign a_exp  = in_a[W-2:MAN_W];
    assign a_man  = in_a[MAN_W-1:0];
    assign b_sign = in_b[W-1] ^ in_op;
    assign b_exp  = in_b[W-2:MAN_W];
    assign b_man  = in_b[MAN_W-1:0];

    assign a_cls  = classify(a_exp == '0, &a_exp, a_man == '0);
    assign b_cls  = classify(b_exp == '0, &b_exp, b_man == '0);
    assign a_mag  = (a_cls == ZERO) ? '0 : {a_exp, a_man};
    assign b_mag  = (b_cls == ZERO) ? '0 : {b_exp, b_man};
    assign a_ge_b = a_mag >= b_mag;

    // Decide special results up front; otherwise prepare the larger/smaller pair.
    always_comb begin
        s1_d.ctl.sign    = a_ge_b ? a_sign : b_sign;
        s1_d.ctl.eff_sub = a_sign ^ b_sign;
        s1_d.exp         = a_ge_b ? a_exp : b_exp;
        s1_d.sig_l       = a_ge_b ? {1'b1, a_man} : {1'b1, b_man};
        s1_d.sig_s       = a_ge_b ? {1'b1, b_man} : {1'b1, a_man};
        s1_d.diff        = a_ge_b ? (a_exp - b_exp) : (b_exp - a_exp);
        s1_d.ctl.bypass  = 1'b1;
        s1_d.ctl.flags   = '0;
        s1_d.byp_result  = '0;
        if (a_cls == NAN || b_cls == NAN) begin
            s1_d.byp_result = QNAN;
        end else if (a_cls == INF && b_cls == INF) begin
            if (a_sign != b_sign) begin
                s1_d.byp_result                 = QNAN;
                s1_d.ctl.flags[FLAG_INVALID]    = 1'b1;
            end else begin
                s1_d.byp_result = {a_sign, INF_POS[W-2:0]};
            end
        end else if (a_cls == INF) begin
            s1_d.byp_result = {a_sign, INF_POS[W-2:0]};
        end else if (b_cls == INF) begin
            s1_d.byp_result = {b_sign, INF_POS[W-2:0]};
        end else if (a_cls == ZERO && b_cls == ZERO) begin
            // Only two negative zeros keep a negative sign.
            s1_d.byp_result = {a_sign & b_sign, {(W-1){1'b0}}};
        end else if (a_cls == ZERO) begin
            s1_d.byp_result = {b_sign, b_exp, b_man};
        end else if (b_cls == ZERO) begin
            s1_d.byp_result = in_a;
        end else begin
            s1_d.ctl.bypass = 1'b0;
        end
    end

    // ---------------- S2: align the smaller significand
    logic [SH_W-1:0]         s2_sh;
    logic [EXT_W+MAX_SH-1:0] s2_wide, s2_shifted;

    // Shift right with the spilled bits collapsed into the sticky position.
    always_comb begin
        s2_sh      = (int'(s1_q.diff) > MAX_SH) ? SH_W'(MAX_SH) : SH_W'(s1_q.diff);
        s2_wide    = {s1_q.sig_s, 3'b000, {MAX_SH{1'b0}}};
        s2_shifted = s2_wide >> s2_sh;
        s2_d.ctl        = s1_q.ctl;
        s2_d.byp_result = s1_q.byp_result;
        s2_d.exp        = s1_q.exp;
        s2_d.sig_l      = {s1_q.sig_l, 3'b000};
        s2_d.sig_s      = {s2_shifted[EXT_W+MAX_SH-1:MAX_SH+1],
                           s2_shifted[MAX_SH] | (|s2_shifted[MAX_SH-1:0])};
    end

    // ---------------- S3: add or subtract, count leading zeros
    logic [SUM_W-1:0] s3_sum;
    logic [LZ_W-1:0]  s3_lz;

    fp_lzc #(.W(EXT_W)) u_lzc (
        .din   (s3_sum[EXT_W-1:0]),
        .count (s3_lz)
    );

    // Larger magnitude is always the minuend, so the difference is never negative.
    always_comb begin
        s3_sum = s2_q.ctl.eff_sub ? ({1'b0, s2_q.sig_l} - {1'b0, s2_q.sig_s})
                                  : ({1'b0, s2_q.sig_l} + {1'b0, s2_q.sig_s});
        s3_d.ctl        = s2_q.ctl;
        s3_d.byp_result = s2_q.byp_result;
        s3_d.exp        = s2_q.exp;
        s3_d.sum        = s3_sum;
        s3_d.lz         = s3_lz;
    end

    // ---------------- S4: normalise, round to nearest even, pack
    logic signed [EXPS_W-1:0] s4_exp_in, s4_lz, s4_exp_n, s4_exp_r;
    logic [EXT_W-1:0]         s4_norm;
    logic [MAN_W:0]           s4_man_r;
    logic [MAN_W-1:0]         s4_man;
    logic                     s4_rnd, s4_inexact;
    logic [W-1:0]             s4_result;
    logic [NUM_FLAGS-1:0]     s4_flags;

    // Normalise, round, then resolve zero / overflow / underflow / normal result.
    always_comb begin
        s4_exp_in = $signed(EXPS_W'(s3_q.exp));
        s4_lz     = $signed(EXPS_W'(s3_q.lz));
        if (s3_q.sum[SUM_W-1]) begin
            s4_norm  = {s3_q.sum[SUM_W-1:2], |s3_q.sum[1:0]};
            s4_exp_n = s4_exp_in + EXPS_W'(1);
        end else begin
            s4_norm  = s3_q.sum[EXT_W-1:0] << s3_q.lz;
            s4_exp_n = s4_exp_in - s4_lz;
        end
        s4_rnd     = s4_norm[2] & (s4_norm[1] | s4_norm[0] | s4_norm[3]);
        s4_inexact = |s4_norm[2:0];
        s4_man_r   = {1'b0, s4_norm[EXT_W-2:3]} + (MAN_W+1)'(s4_rnd);
        // A rounding carry leaves 10.00..0: bump the exponent, mantissa becomes zero.
        s4_exp_r   = s4_exp_n + $signed({{(EXPS_W-1){1'b0}}, s4_man_r[MAN_W]});
        s4_man     = s4_man_r[MAN_W] ? '0 : s4_man_r[MAN_W-1:0];

        s4_result = '0;
        s4_flags  = '0;
        if (s3_q.ctl.bypass) begin
            s4_result = s3_q.byp_result;
            s4_flags  = s3_q.ctl.flags;
        end else if (!s4_norm[EXT_W-1]) begin
            // Normalised MSB clear only for an exact zero difference: +0.
            s4_result = '0;
        end else if (s4_exp_r >= EXP_MAX_S) begin
            s4_result                = {s3_q.ctl.sign, INF_POS[W-2:0]};
            s4_flags[FLAG_OVERFLOW]  = 1'b1;
            s4_flags[FLAG_INEXACT]   = 1'b1;
        end else if (s4_exp_r[EXPS_W-1] || s4_exp_r == '0) begin
            s4_result                = {s3_q.ctl.sign, {(W-1){1'b0}}};
            s4_flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            s4_result                = {s3_q.ctl.sign, s4_exp_r[EXP_W-1:0], s4_man};
            s4_flags[FLAG_INEXACT]   = s4_inexact;
        end
    end

    // ---------------- Registers
    // Stage valid bits: cleared by reset so in-flight work is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            v1_q      <= in_valid;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            out_valid <= v3_q;
        end
    end

    // Stage payloads: meaningful only under their valid bit.
    always_ff @(posedge clk) begin
        // NOTE: datapath payloads are deliberately left unreset; the valid bits qualify them.
        if (advance) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Output registers: cleared on reset, frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_flags  <= '0;
        end else if (advance) begin
            out_result <= s4_result;
            out_flags  <= s4_flags;
        end
    end

endmodule
